// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the branch target buffer.
//   weak_t / weak_nt : weakly-taken / weakly-not-taken counter encodings for a given counter width
//   hash_mode_e      : index hash selection (fold-add of the whole PC, or a word-aligned PC slice)
package btb_pkg;
    typedef enum int {HASH_FOLD = 0, HASH_SLICE = 1} hash_mode_e;

    function automatic int unsigned weak_t(int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned weak_nt(int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction
endpackage

// File: rtl/btb_index_hash.sv
// btb_index_hash: combinational PC to table index.
//   pc_i  in  ADDR_W  program counter
//   idx_o out IDX_W   table index
module btb_index_hash
    import btb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 4,
    parameter int HASH_MODE = 0
) (
    input  logic [ADDR_W-1:0] pc_i,
    output logic [IDX_W-1:0]  idx_o
);
    localparam int NCH = (ADDR_W + IDX_W - 1) / IDX_W;

    logic [NCH*IDX_W-1:0] pc_ext;
    logic [IDX_W-1:0]     fold;

    // The last partial chunk is zero-extended; the sum wraps modulo ENTRIES.
    always_comb begin
        pc_ext = (NCH*IDX_W)'(pc_i);
        fold   = '0;
        for (int i = 0; i < NCH; i++) fold = fold + pc_ext[i*IDX_W +: IDX_W];
    end

    assign idx_o = (HASH_MODE == int'(HASH_SLICE)) ? pc_i[IDX_W+1:2] : fold;
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters and mispredict redirect.
//   clk, rst                         clock, synchronous active-high reset
//   flush                            invalidate all entries at the next edge
//   lk_valid, lk_pc                  fetch lookup request
//   lk_hit, lk_taken, lk_target      combinational prediction
//   up_valid, up_pc, up_target,
//   up_taken, up_pred_taken,
//   up_pred_target                   resolved branch from execute
//   redirect_valid, redirect_pc      registered one-cycle redirect on mispredict
//   stat_lookups, stat_hits,
//   stat_mispred                     saturating statistics
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_W      = 2,
    parameter int HASH_MODE  = 0,
    parameter int INSN_BYTES = 4,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic [ADDR_W-1:0] up_target,
    input  logic              up_taken,
    input  logic              up_pred_taken,
    input  logic [ADDR_W-1:0] up_pred_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(weak_t(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(weak_nt(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t        tbl_q [ENTRIES];
    btb_entry_t        tbl_d [ENTRIES];
    btb_entry_t        lk_e, up_e;
    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic              up_hit, mispred;
    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [STAT_W-1:0] stat_lookups_q, stat_hits_q, stat_mispred_q;

    btb_index_hash #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .HASH_MODE(HASH_MODE)) u_lk_hash (
        .pc_i(lk_pc), .idx_o(lk_idx)
    );
    btb_index_hash #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .HASH_MODE(HASH_MODE)) u_up_hash (
        .pc_i(up_pc), .idx_o(up_idx)
    );

    assign lk_e      = tbl_q[lk_idx];
    assign up_e      = tbl_q[up_idx];
    assign lk_hit    = lk_valid && lk_e.valid && (lk_e.tag == lk_pc);
    assign lk_taken  = lk_hit && lk_e.ctr[CTR_W-1];
    assign lk_target = lk_taken ? lk_e.target : '0;
    assign up_hit    = up_e.valid && (up_e.tag == up_pc);

    assign mispred       = up_valid && ((up_taken != up_pred_taken) || (up_taken && (up_pred_target != up_target)));
    assign redirect_pc_d = up_taken ? up_target : up_pc + ADDR_W'(INSN_BYTES);

    // Flush takes priority over a same-cycle update; counters survive a flush.
    always_comb begin
        tbl_d = tbl_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
        end else if (up_valid && up_hit) begin
            tbl_d[up_idx].ctr = up_taken ? ((up_e.ctr == '1) ? up_e.ctr : up_e.ctr + 1'b1)
                                         : ((up_e.ctr == '0) ? up_e.ctr : up_e.ctr - 1'b1);
            tbl_d[up_idx].target = up_taken ? up_target : up_e.target;
        end else if (up_valid) begin
            tbl_d[up_idx] = '{valid: 1'b1, tag: up_pc, target: up_target, ctr: up_taken ? CTR_WT : CTR_WNT};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stat_lookups_q   <= '0;
            stat_hits_q      <= '0;
            stat_mispred_q   <= '0;
        end else begin
            tbl_q            <= tbl_d;
            redirect_valid_q <= mispred;
            redirect_pc_q    <= mispred ? redirect_pc_d : redirect_pc_q;
            // Each stat adds one only while it is below all-ones, so it saturates.
            stat_lookups_q   <= stat_lookups_q + STAT_W'(lk_valid && (stat_lookups_q != '1));
            stat_hits_q      <= stat_hits_q + STAT_W'(lk_hit && (stat_hits_q != '1));
            stat_mispred_q   <= stat_mispred_q + STAT_W'(mispred && (stat_mispred_q != '1));
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stat_lookups   = stat_lookups_q;
    assign stat_hits      = stat_hits_q;
    assign stat_mispred   = stat_mispred_q;
endmodule
